// File: rtl/prbs_checker_if.sv
// prbs_checker_if: bundles the serial input, its strobe, the error-counter clear and the
// status/error outputs of prbs_checker.
//   master : the data source / host side (drives din, din_valid, clear_err)
//   slave  : the checker itself (drives locked, bit_err, lock_lost, err_count)
//   din        serial data bit
//   din_valid  din is sampled only when high
//   clear_err  synchronous clear of err_count
//   locked     high while the checker is locked
//   bit_err    one-cycle pulse per counted error
//   lock_lost  one-cycle pulse when lock is dropped
//   err_count  saturating error count, ERR_W bits
interface prbs_checker_if #(
   parameter int unsigned ERR_W = 16
) ();

   logic             din;
   logic             din_valid;
   logic             clear_err;
   logic             locked;
   logic             bit_err;
   logic             lock_lost;
   logic [ERR_W-1:0] err_count;

   modport master (
      output din,
      output din_valid,
      output clear_err,
      input  locked,
      input  bit_err,
      input  lock_lost,
      input  err_count
   );

   modport slave (
      input  din,
      input  din_valid,
      input  clear_err,
      output locked,
      output bit_err,
      output lock_lost,
      output err_count
   );

endinterface

// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising PRBS receiver for BER testing.
// A local Fibonacci LFSR is seeded from the incoming stream, verified against it for
// LOCK_COUNT consecutive bits and then run as a flywheel that predicts every bit. While
// locked, mismatches are flagged and counted; LOSS_ERRS consecutive mismatches drop lock
// and the checker reseeds itself.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous, active-high reset
//   bus  prbs_checker_if slave modport (din, din_valid, clear_err in;
//        locked, bit_err, lock_lost, err_count out; all outputs registered)
module prbs_checker #(
   parameter int unsigned       LENGTH     = 8,
   parameter logic [LENGTH-1:0] TAPS       = 8'hB8,
   parameter int unsigned       LOCK_COUNT = 16,
   parameter int unsigned       LOSS_ERRS  = 4,
   parameter int unsigned       ERR_W      = 16
) (
   input logic           clk,
   input logic           rst,
   prbs_checker_if.slave bus
);

   localparam int unsigned FillW  = $clog2(LENGTH + 1);
   localparam int unsigned MatchW = $clog2(LOCK_COUNT + 1);
   localparam int unsigned RunW   = $clog2(LOSS_ERRS + 1);

   localparam logic [FillW-1:0]  FillLast  = FillW'(LENGTH - 1);
   localparam logic [MatchW-1:0] MatchLast = MatchW'(LOCK_COUNT - 1);
   localparam logic [RunW-1:0]   RunLast   = RunW'(LOSS_ERRS - 1);
   localparam logic [ERR_W-1:0]  ErrMax    = {ERR_W{1'b1}};

   typedef enum logic [1:0] {
      StSeed,
      StVerify,
      StLocked
   } st_e;

   st_e                fsm_q, fsm_d;
   logic [LENGTH-1:0]  state_q, state_d;
   logic [FillW-1:0]   fill_q, fill_d;
   logic [MatchW-1:0]  match_q, match_d;
   logic [RunW-1:0]    run_q, run_d;

   logic               locked_q, locked_d;
   logic               bit_err_q, bit_err_d;
   logic               lock_lost_q, lock_lost_d;
   logic [ERR_W-1:0]   err_count_q, err_count_d;

   logic               pred;
   logic               mismatch;
   logic               state_zero;
   logic               count_err;

   // Prediction of the next stream bit from the current LFSR contents.
   assign pred       = ^(state_q & TAPS);
   assign mismatch   = bus.din ^ pred;
   assign state_zero = (state_q == '0);

   // Only mismatches seen while locked are genuine bit errors; before lock they merely
   // restart acquisition.
   assign count_err  = bus.din_valid && (fsm_q == StLocked) && mismatch;

   //--------------------------------------------------------------------------------------
   // State register
   //--------------------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm_q       <= StSeed;
         state_q     <= '0;
         fill_q      <= '0;
         match_q     <= '0;
         run_q       <= '0;
         locked_q    <= 1'b0;
         bit_err_q   <= 1'b0;
         lock_lost_q <= 1'b0;
         err_count_q <= '0;
      end else begin
         fsm_q       <= fsm_d;
         state_q     <= state_d;
         fill_q      <= fill_d;
         match_q     <= match_d;
         run_q       <= run_d;
         locked_q    <= locked_d;
         bit_err_q   <= bit_err_d;
         lock_lost_q <= lock_lost_d;
         err_count_q <= err_count_d;
      end
   end

   //--------------------------------------------------------------------------------------
   // Next-state logic: FSM, LFSR contents and acquisition/loss counters
   //--------------------------------------------------------------------------------------
   always_comb begin
      fsm_d   = fsm_q;
      state_d = state_q;
      fill_d  = fill_q;
      match_d = match_q;
      run_d   = run_q;

      if (bus.din_valid) begin
         unique case (fsm_q)
            StSeed: begin
               state_d = {state_q[LENGTH-2:0], bus.din};
               fill_d  = fill_q + FillW'(1);
               if (fill_q == FillLast) begin
                  fsm_d   = StVerify;
                  match_d = '0;
               end
            end

            StVerify: begin
               state_d = {state_q[LENGTH-2:0], bus.din};
               if (mismatch) begin
                  // The offending bit is already in the register, so it is fill bit one.
                  fsm_d   = StSeed;
                  fill_d  = FillW'(1);
                  match_d = '0;
               end else if (state_zero) begin
                  // An all-zero register trivially predicts zeros; never let it lock.
                  match_d = '0;
               end else begin
                  match_d = match_q + MatchW'(1);
                  if (match_q == MatchLast) begin
                     fsm_d = StLocked;
                     run_d = '0;
                  end
               end
            end

            StLocked: begin
               // Flywheel: feed back the prediction so a corrupted bit cannot poison the
               // register and cause a burst of follow-on errors.
               state_d = {state_q[LENGTH-2:0], pred};
               if (mismatch) begin
                  if (run_q == RunLast) begin
                     fsm_d   = StSeed;
                     fill_d  = '0;
                     match_d = '0;
                     run_d   = '0;
                  end else begin
                     run_d = run_q + RunW'(1);
                  end
               end else begin
                  run_d = '0;
               end
            end

            default: begin
               fsm_d  = StSeed;
               fill_d = '0;
            end
         endcase
      end
   end

   //--------------------------------------------------------------------------------------
   // Output logic (next values of the registered outputs)
   //--------------------------------------------------------------------------------------
   always_comb begin
      locked_d    = (fsm_d == StLocked);
      bit_err_d   = count_err;
      lock_lost_d = count_err && (run_q == RunLast);

      err_count_d = err_count_q;
      if (bus.clear_err) begin
         // A clear coinciding with a counted error leaves exactly that error on record.
         err_count_d = ERR_W'(count_err);
      end else if (count_err && (err_count_q != ErrMax)) begin
         err_count_d = err_count_q + ERR_W'(1);
      end
   end

   assign bus.locked    = locked_q;
   assign bus.bit_err   = bit_err_q;
   assign bus.lock_lost = lock_lost_q;
   assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker: randomized scoreboard bench for prbs_checker.
// Two checkers share one stimulus stream: one with a 16-bit error counter and one with a
// 4-bit counter, so saturation is visible while everything else must agree. The driver
// updates a reference model at each falling edge and queues the expected registered
// outputs; a monitor pops one entry per rising edge and compares both instances.
module tb_prbs_checker;

   localparam int unsigned L  = 8;
   localparam int unsigned LC = 16;
   localparam int unsigned LE = 4;

   localparam int MSeed   = 0;
   localparam int MVerify = 1;
   localparam int MLocked = 2;

   typedef struct {
      bit          locked;
      bit          bit_err;
      bit          lock_lost;
      int unsigned err16;
      int unsigned err4;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;

   always #5 clk = ~clk;

   prbs_checker_if #(.ERR_W(16)) bus16 ();
   prbs_checker_if #(.ERR_W(4))  bus4 ();

   prbs_checker #(
      .LENGTH(8), .TAPS(8'hB8), .LOCK_COUNT(16), .LOSS_ERRS(4), .ERR_W(16)
   ) dut16 (
      .clk(clk),
      .rst(rst),
      .bus(bus16.slave)
   );

   prbs_checker #(
      .LENGTH(8), .TAPS(8'hB8), .LOCK_COUNT(16), .LOSS_ERRS(4), .ERR_W(4)
   ) dut4 (
      .clk(clk),
      .rst(rst),
      .bus(bus4.slave)
   );

   int          n_tests = 0;
   int          n_fail  = 0;
   exp_t        exp_q[$];

   // Reference model: recent accepted bits (index 0 = newest), acquisition phase and
   // plain integer counters; error total is unbounded and saturated only when compared.
   logic [7:0]  taps_v = 8'hB8;
   bit          hist[$];
   int          mode;
   int          fill, match, run;
   int unsigned errs;
   logic [7:0]  gen_s;

   function automatic void check(input string name, input longint unsigned act,
                                 input longint unsigned req);
      n_tests++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, req, $time);
      end
   endfunction

   function automatic int unsigned sat(input int unsigned v, input int unsigned lim);
      return (v > lim) ? lim : v;
   endfunction

   function automatic bit ref_pred();
      bit p = 1'b0;
      for (int k = 0; k < L; k++) if (taps_v[k]) p ^= hist[k];
      return p;
   endfunction

   function automatic bit hist_zero();
      for (int k = 0; k < L; k++) if (hist[k]) return 1'b0;
      return 1'b1;
   endfunction

   function automatic void hist_push(input bit b);
      hist.push_front(b);
      void'(hist.pop_back());
   endfunction

   function automatic void model_reset();
      hist = {};
      for (int k = 0; k < L; k++) hist.push_back(1'b0);
      mode  = MSeed;
      fill  = 0;
      match = 0;
      run   = 0;
      errs  = 0;
   endfunction

   // Reference PRBS generator: each output bit is the tap parity of the last eight bits.
   function automatic void gen_reset();
      gen_s = 8'h01;
   endfunction

   function automatic bit gen_next();
      bit o = ^(gen_s & taps_v);
      gen_s = {gen_s[6:0], o};
      return o;
   endfunction

   function automatic void model_step(input bit d, input bit v, input bit c);
      bit   err  = 1'b0;
      bit   lost = 1'b0;
      bit   p;
      bit   z;
      exp_t e;
      if (v) begin
         p = ref_pred();
         z = hist_zero();
         case (mode)
            MSeed: begin
               hist_push(d);
               fill++;
               if (fill == L) begin
                  mode  = MVerify;
                  match = 0;
               end
            end
            MVerify: begin
               hist_push(d);
               if (d != p) begin
                  mode  = MSeed;
                  fill  = 1;
                  match = 0;
               end else if (z) begin
                  match = 0;
               end else begin
                  match++;
                  if (match == LC) begin
                     mode = MLocked;
                     run  = 0;
                  end
               end
            end
            default: begin
               hist_push(p);
               if (d != p) begin
                  err = 1'b1;
                  run++;
                  if (run == LE) begin
                     mode = MSeed;
                     fill = 0;
                     run  = 0;
                     lost = 1'b1;
                  end
               end else begin
                  run = 0;
               end
            end
         endcase
      end
      if (c) errs = err ? 1 : 0;
      else if (err) errs++;
      e.locked    = (mode == MLocked);
      e.bit_err   = err;
      e.lock_lost = lost;
      e.err16     = sat(errs, 65535);
      e.err4      = sat(errs, 15);
      exp_q.push_back(e);
   endfunction

   task automatic set_in(input bit d, input bit v, input bit c);
      bus16.din = d; bus16.din_valid = v; bus16.clear_err = c;
      bus4.din  = d; bus4.din_valid  = v; bus4.clear_err  = c;
   endtask

   task automatic drive(input bit d, input bit v, input bit c);
      @(negedge clk);
      set_in(d, v, c);
      model_step(d, v, c);
   endtask

   // Next generator bit, optionally inverted, presented as a valid bit.
   task automatic send(input bit inv, input bit c);
      bit b = gen_next();
      drive(b ^ inv, 1'b1, c);
   endtask

   task automatic idle(input bit c);
      drive(1'($urandom_range(0, 1)), 1'b0, c);
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_locked"},    bus16.locked,    0);
      check({tag, "_bit_err"},   bus16.bit_err,   0);
      check({tag, "_lock_lost"}, bus16.lock_lost, 0);
      check({tag, "_err16"},     bus16.err_count, 0);
      check({tag, "_locked4"},   bus4.locked,     0);
      check({tag, "_err4"},      bus4.err_count,  0);
   endtask

   // Reset asserted between clock edges; outputs must clear before the next edge.
   task automatic async_reset(input string tag);
      @(posedge clk);
      #3;
      rst = 1'b1;
      set_in(1'b0, 1'b0, 1'b0);
      #1;
      check_zero_outputs(tag);
      model_reset();
      gen_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic sample_point();
      @(posedge clk);
      #3;
   endtask

   // Monitor: one expectation per rising edge that followed a driven cycle.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("locked",     bus16.locked,    e.locked);
            check("bit_err",    bus16.bit_err,   e.bit_err);
            check("lock_lost",  bus16.lock_lost, e.lock_lost);
            check("err_count",  bus16.err_count, e.err16);
            check("locked_w4",  bus4.locked,     e.locked);
            check("err_count4", bus4.err_count,  e.err4);
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish, expected finish before t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      set_in(1'b0, 1'b0, 1'b0);
      model_reset();
      gen_reset();
      #1;
      rst = 1'b1;
      #1;
      check_zero_outputs("reset");
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // 1: clean lock after exactly 24 bits, then a long clean run.
      for (int i = 0; i < 23; i++) send(1'b0, 1'b0);
      sample_point();
      check("s1_not_locked_23", bus16.locked, 0);
      send(1'b0, 1'b0);
      sample_point();
      check("s1_locked_24", bus16.locked, 1);
      for (int i = 0; i < 1000; i++) send(1'b0, 1'b0);
      sample_point();
      check("s1_err_count", bus16.err_count, 0);

      // 2: a single inverted bit is counted once and lock holds.
      send(1'b1, 1'b0);
      sample_point();
      check("s2_bit_err", bus16.bit_err, 1);
      check("s2_err_count", bus16.err_count, 1);
      for (int i = 0; i < 20; i++) send(1'b0, 1'b0);

      // 3: four consecutive errors drop lock; relock after 24 clean bits.
      send(1'b0, 1'b1);
      for (int i = 0; i < LE; i++) send(1'b1, 1'b0);
      sample_point();
      check("s3_lock_lost", bus16.lock_lost, 1);
      check("s3_err_count", bus16.err_count, 4);
      for (int i = 0; i < 40; i++) send(1'b0, 1'b0);
      sample_point();
      check("s3_relocked", bus16.locked, 1);

      // 4: valid one cycle in three, random din while invalid.
      async_reset("s4_reset");
      for (int i = 0; i < 60; i++) begin
         idle(1'b0);
         idle(1'b0);
         send(1'b0, 1'b0);
      end

      // 5: saturation, clear coinciding with an error, clear alone.
      for (int i = 0; i < 20; i++) begin
         send(1'b1, 1'b0);
         for (int j = 0; j < 3; j++) send(1'b0, 1'b0);
      end
      sample_point();
      check("s5_sat4", bus4.err_count, 15);
      send(1'b1, 1'b1);
      sample_point();
      check("s5_clear_with_err", bus16.err_count, 1);
      for (int i = 0; i < 3; i++) send(1'b0, 1'b0);
      idle(1'b1);
      sample_point();
      check("s5_clear_alone", bus16.err_count, 0);

      // 6: all-zero stream never locks; then lock, error, and asynchronous reset.
      async_reset("s6_reset_a");
      for (int i = 0; i < 100; i++) drive(1'b0, 1'b1, 1'b0);
      sample_point();
      check("s6_zero_not_locked", bus16.locked, 0);
      for (int i = 0; i < 60; i++) send(1'b0, 1'b0);
      send(1'b1, 1'b0);
      async_reset("s6_reset_mid");
      for (int i = 0; i < 24; i++) send(1'b0, 1'b0);
      sample_point();
      check("s6_relock_24", bus16.locked, 1);

      // 7: random valid gaps, errors, error bursts and clears.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 249) == 0) begin
            for (int j = 0; j < LE; j++) send(1'b1, 1'b0);
         end else if ($urandom_range(0, 3) == 0) begin
            idle($urandom_range(0, 49) == 0);
         end else begin
            send($urandom_range(0, 24) == 0, $urandom_range(0, 49) == 0);
         end
      end

      drive(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
      #3;
      check("queue_drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
